// File: rtl/cs_rr_arbiter.sv
// rtl/cs_rr_arbiter.sv - round-robin arbiter driving a 74x139-style 2-to-4 active-low decoder
// Grants are tenure-limited and separated by one break-before-make cycle.
module cs_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [3:0] REQ_L,
  input  logic       DONE_L,
  output logic       G_L,
  output logic       A,
  output logic       B,
  output logic [3:0] Y_L,
  output logic       TO_L
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    sel_q, sel_d;
  logic          g_l_q, g_l_d;
  logic [3:0]    y_l_q, y_l_d;
  logic          to_l_q, to_l_d;

  logic          win_valid;
  logic [1:0]    win_idx;
  logic          rel_done, rel_wd, rel_to, rel_any;

  // Scan starts just after the last owner, so a still-requesting owner is considered last.
  always_comb begin
    logic [1:0] idx;
    win_valid = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!win_valid && !REQ_L[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign rel_done = !DONE_L;
  assign rel_wd   = REQ_L[sel_q];
  assign rel_to   = (cnt_q == CW'(TIMEOUT - 1));
  assign rel_any  = rel_done || rel_wd || rel_to;

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      g_l_q   <= 1'b1;
      y_l_q   <= 4'b1111;
      to_l_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      g_l_q   <= g_l_d;
      y_l_q   <= y_l_d;
      to_l_q  <= to_l_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (win_valid) state_d = S_GRANT;
      S_GRANT:   if (rel_any) state_d = S_RELEASE;
      S_RELEASE: state_d = win_valid ? S_GRANT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    sel_d  = sel_q;
    g_l_d  = g_l_q;
    to_l_d = 1'b1;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        g_l_d = 1'b1;
        if (win_valid) begin
          sel_d  = win_idx;
          last_d = win_idx;
          g_l_d  = 1'b0;
          cnt_d  = '0;
        end
      end
      S_GRANT: begin
        if (rel_any) begin
          g_l_d  = 1'b1;
          to_l_d = !(rel_to && !rel_done && !rel_wd);
        end else if (!rel_to) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        g_l_d = 1'b1;
      end
    endcase
    // Decode from next-state values so Y_L can never disagree with G_L/{B,A}.
    y_l_d = g_l_d ? 4'b1111 : ~(4'b0001 << sel_d);
  end

  assign G_L  = g_l_q;
  assign A    = sel_q[0];
  assign B    = sel_q[1];
  assign Y_L  = y_l_q;
  assign TO_L = to_l_q;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// tb/tb_cs_rr_arbiter.sv - directed and random checks of cs_rr_arbiter against a tenure-based model
module tb_cs_rr_arbiter;

  localparam int T = 4;

  logic       CLK;
  logic       RESET_L;
  logic [3:0] REQ_L;
  logic       DONE_L;
  logic       G_L, A, B, TO_L;
  logic [3:0] Y_L;

  int errors = 0;
  int checks = 0;

  // Model: who owns the decoder, for how many cycles, and who was served last.
  int         m_owner;
  int         m_tenure;
  int         m_last;
  logic [1:0] m_ba;
  logic       m_to;

  cs_rr_arbiter #(.TIMEOUT(T), .CW(8)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .REQ_L(REQ_L), .DONE_L(DONE_L),
    .G_L(G_L), .A(A), .B(B), .Y_L(Y_L), .TO_L(TO_L)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    int c;
    if (!RESET_L) begin
      m_owner = -1; m_tenure = 0; m_last = 3; m_ba = 2'd0; m_to = 1'b1;
    end else if (m_owner >= 0) begin
      m_tenure++;
      if (!DONE_L || REQ_L[m_owner] || m_tenure == T) begin
        m_to    = !(m_tenure == T && DONE_L && !REQ_L[m_owner]);
        m_owner = -1;
      end else begin
        m_to = 1'b1;
      end
    end else begin
      m_to = 1'b1;
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (w < 0 && !REQ_L[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w; m_last = w; m_ba = 2'(w); m_tenure = 0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] ey;
    @(posedge CLK);
    model_edge();
    #1;
    ey = 4'b1111;
    if (m_owner >= 0) ey[m_owner] = 1'b0;
    chk("G_L", {3'b0, G_L}, {3'b0, m_owner < 0});
    chk("BA", {2'b0, B, A}, {2'b0, m_ba});
    chk("Y_L", Y_L, ey);
    chk("TO_L", {3'b0, TO_L}, {3'b0, m_to});
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq[0] = 4'b1110; rr_seq[1] = 4'b1101; rr_seq[2] = 4'b1011;
    rr_seq[3] = 4'b0111; rr_seq[4] = 4'b1110;
    m_owner = -1; m_tenure = 0; m_last = 3; m_ba = 2'd0; m_to = 1'b1;
    RESET_L = 1'b0; REQ_L = 4'b0000; DONE_L = 1'b1;

    // reset, then first grant goes to requester 0
    step(); step();
    chk("tp1_reset_y", Y_L, 4'b1111);
    chk("tp1_reset_g", {3'b0, G_L}, 4'd1);
    RESET_L = 1'b1;
    step();
    chk("tp1_first_grant", Y_L, 4'b1110);
    REQ_L = 4'b1111;
    step(); step();

    // single request, released by DONE_L
    REQ_L = 4'b1101;
    step();
    chk("tp2_grant", Y_L, 4'b1101);
    DONE_L = 1'b0; REQ_L = 4'b1111;
    step();
    chk("tp2_release", Y_L, 4'b1111);
    DONE_L = 1'b1;
    step();
    chk("tp2_idle", Y_L, 4'b1111);

    // round robin with two-cycle tenures
    RESET_L = 1'b0; REQ_L = 4'b0000;
    step(); step();
    RESET_L = 1'b1;
    step();
    chk("tp3_rr0", Y_L, rr_seq[0]);
    for (int g = 1; g < 5; g++) begin
      DONE_L = 1'b1; step();
      chk("tp3_hold", Y_L, rr_seq[g-1]);
      DONE_L = 1'b0; step();
      chk("tp3_gap", Y_L, 4'b1111);
      DONE_L = 1'b1; step();
      chk("tp3_rr", Y_L, rr_seq[g]);
    end

    // timeout with a sole requester
    RESET_L = 1'b0; REQ_L = 4'b1011;
    step();
    RESET_L = 1'b1;
    step();
    for (int i = 0; i < T - 1; i++) step();
    chk("tp4_last_low", Y_L, 4'b1011);
    step();
    chk("tp4_gap_y", Y_L, 4'b1111);
    chk("tp4_to", {3'b0, TO_L}, 4'd0);
    step();
    chk("tp4_regrant", Y_L, 4'b1011);
    chk("tp4_to_clear", {3'b0, TO_L}, 4'd1);

    // withdrawal, and DONE_L coinciding with the timeout edge
    RESET_L = 1'b0; REQ_L = 4'b0111;
    step();
    RESET_L = 1'b1;
    step();
    chk("tp5_own3", Y_L, 4'b0111);
    REQ_L = 4'b1111;
    step();
    chk("tp5_wd_y", Y_L, 4'b1111);
    chk("tp5_wd_to", {3'b0, TO_L}, 4'd1);
    step();
    REQ_L = 4'b1011;
    step();
    for (int i = 0; i < T - 1; i++) step();
    DONE_L = 1'b0;
    step();
    chk("tp5_done_to", {3'b0, TO_L}, 4'd1);
    chk("tp5_done_y", Y_L, 4'b1111);
    DONE_L = 1'b1;

    // reset in the middle of a grant
    for (int i = 0; i < 20 && Y_L !== 4'b1011; i++) step();
    chk("tp6_wait", Y_L, 4'b1011);
    RESET_L = 1'b0;
    step();
    chk("tp6_rst_y", Y_L, 4'b1111);
    chk("tp6_rst_ba", {2'b0, B, A}, 4'd0);
    RESET_L = 1'b1; REQ_L = 4'b0000;
    step();
    chk("tp6_first", Y_L, 4'b1110);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      REQ_L   = 4'($urandom);
      DONE_L  = ($urandom_range(0, 3) != 0);
      RESET_L = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
